hsi_param_loader: RTL and testbench

- Streams detector coefficients into the target-detection core: inverse-correlation matrix (NUM_BANDS x NUM_BANDS), target signature vector sR, and scalar sRs.
- Input is a single AXI-Stream, replacing per-word register writes.
- Sequences words into the matrix and vector write ports, latches the scalar, then raises start.
- Generalised over band count and word width; supports partial reload modes so matrix upload can be skipped.

---
 rtl/hsi_param_loader.sv | 186 ++++++++++++++++++
 tb/tb_hsi_param_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_param_loader.sv
// Streams detector coefficients (matrix, sR vector, sRs scalar) from one AXI-Stream into write ports; optional checksum via HSI_PARAM_LOADER_CHECKSUM_EN.
// Writes appear 1 cycle after each handshake, start rises 1 cycle after the scalar; 1 word/clk, output side never stalls, tready low only when idle.
module hsi_param_loader #(
   parameter int NUM_BANDS  = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MAT_AW     = $clog2(NUM_BANDS*NUM_BANDS),
   parameter int VEC_AW     = $clog2(NUM_BANDS)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  load_req,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  mat_we,
   output logic [MAT_AW-1:0]     mat_addr,
   output logic [DATA_WIDTH-1:0] mat_wdata,
   output logic                  vec_we,
   output logic [VEC_AW-1:0]     vec_addr,
   output logic [DATA_WIDTH-1:0] vec_wdata,
   output logic [DATA_WIDTH-1:0] srs_out,
   output logic                  start,
   output logic                  busy,
   output logic                  err_short,
   output logic                  err_long,
`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
   input  logic                  clr_checksum,
   output logic [DATA_WIDTH-1:0] checksum,
`endif
   output logic                  err_mode
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_MATRIX = 3'd1;
   localparam logic [2:0] ST_VECTOR = 3'd2;
   localparam logic [2:0] ST_SCALAR = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;

   localparam logic [MAT_AW-1:0] MAT_LAST = MAT_AW'(NUM_BANDS*NUM_BANDS-1);
   localparam logic [MAT_AW-1:0] VEC_LAST = MAT_AW'(NUM_BANDS-1);

   logic [2:0]        state;
   logic [MAT_AW-1:0] cnt;
   logic              accept;
   logic              scalar_done;
   logic              load_go;
   logic [2:0]        load_state;

   assign s_axis_tready = (state != ST_IDLE);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign scalar_done   = (state == ST_SCALAR) && accept && s_axis_tlast;

   // A request landing on the same cycle as the final scalar chains straight
   // into the next load, so start never pulses for the superseded set.
   assign load_go = load_req && (mode != 2'b11) &&
                    ((state == ST_IDLE) || scalar_done);

   always_comb begin
      load_state = ST_SCALAR;
      case (mode)
         2'b00:   load_state = ST_MATRIX;
         2'b01:   load_state = ST_VECTOR;
         default: load_state = ST_SCALAR;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mat_we    <= 1'b0;
         mat_addr  <= '0;
         mat_wdata <= '0;
         vec_we    <= 1'b0;
         vec_addr  <= '0;
         vec_wdata <= '0;
         srs_out   <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         err_mode  <= 1'b0;
      end else begin
         mat_we <= 1'b0;
         vec_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (load_req) begin
                  if (mode == 2'b11) begin
                     err_mode <= 1'b1;
                  end else begin
                     start     <= 1'b0;
                     busy      <= 1'b1;
                     err_short <= 1'b0;
                     err_long  <= 1'b0;
                     err_mode  <= 1'b0;
                     state     <= load_state;
                  end
               end
            end
            ST_MATRIX: begin
               if (accept) begin
                  mat_we    <= 1'b1;
                  mat_addr  <= cnt;
                  mat_wdata <= s_axis_tdata;
                  cnt       <= cnt + 1'b1;
                  if (s_axis_tlast) begin
                     err_short <= 1'b1;
                     busy      <= 1'b0;
                     cnt       <= '0;
                     state     <= ST_IDLE;
                  end else if (cnt == MAT_LAST) begin
                     cnt   <= '0;
                     state <= ST_VECTOR;
                  end
               end
            end
            ST_VECTOR: begin
               if (accept) begin
                  vec_we    <= 1'b1;
                  vec_addr  <= cnt[VEC_AW-1:0];
                  vec_wdata <= s_axis_tdata;
                  cnt       <= cnt + 1'b1;
                  if (s_axis_tlast) begin
                     err_short <= 1'b1;
                     busy      <= 1'b0;
                     cnt       <= '0;
                     state     <= ST_IDLE;
                  end else if (cnt == VEC_LAST) begin
                     cnt   <= '0;
                     state <= ST_SCALAR;
                  end
               end
            end
            ST_SCALAR: begin
               cnt <= '0;
               if (accept) begin
                  srs_out <= s_axis_tdata;
                  if (!s_axis_tlast) begin
                     err_long <= 1'b1;
                     state    <= ST_DRAIN;
                  end else if (load_go) begin
                     err_short <= 1'b0;
                     err_long  <= 1'b0;
                     err_mode  <= 1'b0;
                     state     <= load_state;
                  end else begin
                     start <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DRAIN: begin
               cnt <= '0;
               if (accept && s_axis_tlast) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
   // Drained words are excluded: they belong to no coefficient set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         checksum <= '0;
      end else if (clr_checksum || (load_req && state == ST_IDLE) || load_go) begin
         checksum <= '0;
      end else if (accept && (state == ST_MATRIX || state == ST_VECTOR ||
                              state == ST_SCALAR)) begin
         checksum <= checksum ^ s_axis_tdata;
      end
   end
`endif

endmodule

// File: tb/tb_hsi_param_loader.sv
// Randomized bench for hsi_param_loader: a stream-level model predicts writes, scalar, flags and start per load.
module tb_hsi_param_loader;
   localparam int NB  = 16;
   localparam int DW  = 32;
   localparam int MAW = 8;
   localparam int VAW = 4;
   localparam int ML  = NB*NB;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           load_req = 1'b0;
   logic [1:0]     mode = 2'b00;
   logic [DW-1:0]  s_axis_tdata = '0;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tlast = 1'b0;
   logic           s_axis_tready;
   logic           mat_we, vec_we, start, busy, err_short, err_long, err_mode;
   logic [MAW-1:0] mat_addr;
   logic [VAW-1:0] vec_addr;
   logic [DW-1:0]  mat_wdata, vec_wdata, srs_out;
`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
   logic           clr_checksum = 1'b0;
   logic [DW-1:0]  checksum;
`endif

   hsi_param_loader #(.NUM_BANDS(NB), .DATA_WIDTH(DW)) dut (
      .clk(clk), .resetn(resetn), .load_req(load_req), .mode(mode),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
      .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
      .srs_out(srs_out), .start(start), .busy(busy),
      .err_short(err_short), .err_long(err_long),
`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
      .clr_checksum(clr_checksum), .checksum(checksum),
`endif
      .err_mode(err_mode)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model state and the memory image the DUT actually wrote.
   logic [DW-1:0] m_mat [ML];
   logic [DW-1:0] m_vec [NB];
   logic [DW-1:0] d_mat [ML];
   logic [DW-1:0] d_vec [NB];
   logic [DW-1:0] m_srs = '0;
   logic [DW-1:0] m_ck  = '0;
   bit            m_start, m_short, m_long, m_emode;
   int            mat_wr, vec_wr;
   int unsigned   eq_ma[$];
   int unsigned   eq_va[$];
   logic [DW-1:0] eq_md[$];
   logic [DW-1:0] eq_vd[$];
   logic [DW-1:0] words[$];

   always @(negedge clk) begin
      if (mat_we) begin
         mat_wr++;
         d_mat[mat_addr] = mat_wdata;
         if (eq_ma.size() == 0) chk("mat_we_extra", 64'(mat_we), 64'(0));
         else begin
            chk("mat_addr", 64'(mat_addr), 64'(eq_ma.pop_front()));
            chk("mat_wdata", 64'(mat_wdata), 64'(eq_md.pop_front()));
         end
      end
      if (vec_we) begin
         vec_wr++;
         d_vec[vec_addr] = vec_wdata;
         if (eq_va.size() == 0) chk("vec_we_extra", 64'(vec_we), 64'(0));
         else begin
            chk("vec_addr", 64'(vec_addr), 64'(eq_va.pop_front()));
            chk("vec_wdata", 64'(vec_wdata), 64'(eq_vd.pop_front()));
         end
      end
   end

   // Stream-level prediction: slot i of the load is matrix, vector or scalar
   // by position alone; the tlast position decides short / ok / long.
   task automatic model_load(input logic [1:0] md);
      int m_n, v_n, l_n, n;
      if (md == 2'b11) begin
         m_emode = 1'b1;
         return;
      end
      m_n = (md == 2'b00) ? ML : 0;
      v_n = (md != 2'b10) ? NB : 0;
      l_n = m_n + v_n + 1;
      n   = words.size();
      m_short = 0; m_long = 0; m_emode = 0; m_start = 0; m_ck = '0;
      mat_wr = 0; vec_wr = 0;
      for (int i = 0; i < n && i < l_n; i++) begin
         if (i < m_n) begin
            m_mat[i] = words[i];
            eq_ma.push_back(i);
            eq_md.push_back(words[i]);
         end else if (i < m_n + v_n) begin
            m_vec[i-m_n] = words[i];
            eq_va.push_back(i-m_n);
            eq_vd.push_back(words[i]);
         end else begin
            m_srs = words[i];
         end
         m_ck ^= words[i];
      end
      if (n < l_n) m_short = 1;
      else if (n == l_n) m_start = 1;
      else m_long = 1;
   endtask

   task automatic do_load(input logic [1:0] md);
      load_req = 1'b1;
      mode     = md;
      @(posedge clk); #1;
      load_req = 1'b0;
      if (md != 2'b11) begin
         chk("busy_on_load", 64'(busy), 64'(1));
         chk("start_drop_on_load", 64'(start), 64'(0));
         chk("tready_on_load", 64'(s_axis_tready), 64'(1));
      end
   endtask

   task automatic send(input int gap, input int abort_at);
      int  n;
      bit  acc;
      int  t;
      n = words.size();
      for (int i = 0; i < n; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = words[i];
         s_axis_tlast  = (i == n-1);
         if (i == abort_at) begin
            #2 resetn = 1'b0;
            return;
         end
         acc = 0; t = 0;
         while (!acc && t < 50) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (acc && i == n-1) chk("start_before_last", 64'(start), 64'(0));
            @(posedge clk); #1;
            t++;
         end
         if (!acc) begin
            chk("handshake_timeout", 64'(s_axis_tready), 64'(1));
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            return;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      chk("start_after_last", 64'(start), 64'(m_start));
      chk("busy_after_last", 64'(busy), 64'(0));
      chk("tready_after_last", 64'(s_axis_tready), 64'(0));
   endtask

   task automatic check_end(input bit img);
      repeat (2) @(posedge clk);
      #1;
      chk("start", 64'(start), 64'(m_start));
      chk("busy", 64'(busy), 64'(0));
      chk("tready_idle", 64'(s_axis_tready), 64'(0));
      chk("err_short", 64'(err_short), 64'(m_short));
      chk("err_long", 64'(err_long), 64'(m_long));
      chk("err_mode", 64'(err_mode), 64'(m_emode));
      chk("srs_out", 64'(srs_out), 64'(m_srs));
      chk("mat_writes_missing", 64'(eq_ma.size()), 64'(0));
      chk("vec_writes_missing", 64'(eq_va.size()), 64'(0));
`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(m_ck));
`endif
      if (img) begin
         for (int i = 0; i < ML; i++) chk("mat_image", 64'(d_mat[i]), 64'(m_mat[i]));
         for (int i = 0; i < NB; i++) chk("vec_image", 64'(d_vec[i]), 64'(m_vec[i]));
      end
   endtask

   task automatic run(input logic [1:0] md, input int gap);
      model_load(md);
      do_load(md);
      send(gap, -1);
      check_end(1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int l_n, n, kind;
      logic [1:0] md;
      for (int i = 0; i < ML; i++) begin m_mat[i] = '0; d_mat[i] = '0; end
      for (int i = 0; i < NB; i++) begin m_vec[i] = '0; d_vec[i] = '0; end
      m_start = 0; m_short = 0; m_long = 0; m_emode = 0;

      #12;
      chk("rst_start", 64'(start), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_tready", 64'(s_axis_tready), 64'(0));
      chk("rst_srs", 64'(srs_out), 64'(0));
      chk("rst_errs", 64'({err_short, err_long, err_mode}), 64'(0));
      @(posedge clk); #1 resetn = 1'b1;
      @(posedge clk); #1;

      // Full load, word k = k+1.
      words.delete();
      for (int k = 0; k < ML + NB + 1; k++) words.push_back(DW'(k+1));
      run(2'b00, 0);
      chk("full_mat_count", 64'(mat_wr), 64'(256));
      chk("full_vec_count", 64'(vec_wr), 64'(16));
      chk("full_srs_lit", 64'(srs_out), 64'(273));
      chk("full_mat0_lit", 64'(d_mat[0]), 64'(1));
      chk("full_mat255_lit", 64'(d_mat[255]), 64'(256));
      chk("full_vec15_lit", 64'(d_vec[15]), 64'(272));
      chk("full_start_lit", 64'(start), 64'(1));
`ifdef HSI_PARAM_LOADER_CHECKSUM_EN
      chk("checksum_lit", 64'(checksum), 64'(1));
`endif

      // Reserved mode: flag only, previous start kept.
      model_load(2'b11);
      do_load(2'b11);
      check_end(1'b0);
      chk("resv_start_kept_lit", 64'(start), 64'(1));

      // Vector + scalar reload.
      words.delete();
      for (int k = 0; k < 17; k++) words.push_back(DW'(32'hA0 + k));
      run(2'b01, 0);
      chk("v01_mat_count", 64'(mat_wr), 64'(0));
      chk("v01_srs_lit", 64'(srs_out), 64'(32'hB0));
      chk("v01_vec0_lit", 64'(d_vec[0]), 64'(32'hA0));

      // Short stream: tlast on word 100.
      words.delete();
      for (int k = 0; k < 100; k++) words.push_back($urandom);
      run(2'b00, 0);
      chk("short_mat_count", 64'(mat_wr), 64'(100));
      chk("short_err_lit", 64'(err_short), 64'(1));

      // Long stream: scalar mode, three words.
      words.delete();
      for (int k = 0; k < 3; k++) words.push_back($urandom);
      run(2'b10, 0);
      chk("long_srs_word1", 64'(srs_out), 64'(words[0]));
      chk("long_err_lit", 64'(err_long), 64'(1));

      // Full load with 50% valid gaps, same data as the first load.
      words.delete();
      for (int k = 0; k < ML + NB + 1; k++) words.push_back(DW'(k+1));
      run(2'b00, 50);

      // Random loads of every kind.
      for (int r = 0; r < 8; r++) begin
         md   = 2'($urandom_range(2));
         l_n  = ((md == 2'b00) ? ML : 0) + ((md != 2'b10) ? NB : 0) + 1;
         kind = $urandom_range(2);
         if (kind == 1 && l_n > 1) n = $urandom_range(l_n-1, 1);
         else if (kind == 2) n = l_n + $urandom_range(4, 1);
         else n = l_n;
         words.delete();
         for (int k = 0; k < n; k++) words.push_back($urandom);
         run(md, 50);
      end

      // Reset in the middle of a full reload (at word 130).
      words.delete();
      for (int k = 0; k < ML + NB + 1; k++) words.push_back(DW'(k+1));
      model_load(2'b00);
      do_load(2'b00);
      send(0, 129);
      #1;
      chk("arst_start", 64'(start), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_tready", 64'(s_axis_tready), 64'(0));
      chk("arst_we", 64'({mat_we, vec_we}), 64'(0));
      chk("arst_srs", 64'(srs_out), 64'(0));
      chk("arst_errs", 64'({err_short, err_long, err_mode}), 64'(0));
      eq_ma.delete(); eq_md.delete(); eq_va.delete(); eq_vd.delete();
      m_srs = '0; m_ck = '0; m_start = 0; m_short = 0; m_long = 0; m_emode = 0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      check_end(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
